// File: rtl/motor_drive_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : motor_drive_ctrl_pkg
// Brief    : Shared types and constants for the two-channel motor driver.
// Revision : 1.0 - initial release
// ============================================================================
package motor_drive_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_ZERO = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } chan_state_t;

    // Bridge input pins packed as {x1, x2}
    localparam logic [1:0] c_PINS_COAST = 2'b00;
    localparam logic [1:0] c_PINS_FWD   = 2'b10;
    localparam logic [1:0] c_PINS_REV   = 2'b01;
    localparam logic [1:0] c_PINS_BRAKE = 2'b11;

    localparam logic c_DIR_FWD = 1'b0;
    localparam logic c_DIR_REV = 1'b1;

    function automatic int unsigned f_dmax(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/motor_drive_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : motor_drive_ctrl_if
// Brief    : Command inputs and bridge/telemetry outputs of the motor driver.
// Revision : 1.0 - initial release
// ============================================================================
interface motor_drive_ctrl_if #(
    parameter int W        = 16,
    parameter int PWM_BITS = 8
);
    logic                  ena;
    logic                  brake;
    logic signed [W-1:0]   u_k;
    logic signed [W-1:0]   vr;
    logic [PWM_BITS-1:0]   vmax;

    logic                  pwm_a;
    logic                  dir_a1;
    logic                  dir_a2;
    logic                  pwm_b;
    logic                  dir_b1;
    logic                  dir_b2;
    logic                  stby;
    logic signed [PWM_BITS:0] duty_a;
    logic signed [PWM_BITS:0] duty_b;
    logic                  period_tick;

    modport master (
        output ena, brake, u_k, vr, vmax,
        input  pwm_a, dir_a1, dir_a2, pwm_b, dir_b1, dir_b2,
        input  stby, duty_a, duty_b, period_tick
    );

    modport slave (
        input  ena, brake, u_k, vr, vmax,
        output pwm_a, dir_a1, dir_a2, pwm_b, dir_b1, dir_b2,
        output stby, duty_a, duty_b, period_tick
    );
endinterface
`default_nettype wire

// File: rtl/motor_drive_ctrl_channel.sv
`default_nettype none
// ============================================================================
// Module   : motor_channel
// Brief    : One wheel: target clamp, slew-limited ramp FSM with dead time on
//            reversal, PWM compare and H-bridge pin encoding.
// Revision : 1.0 - initial release
// ============================================================================
module motor_channel
    import motor_drive_ctrl_pkg::*;
#(
    parameter int W            = 16,
    parameter int PWM_BITS     = 8,
    parameter int RAMP_STEP    = 4,
    parameter int DEAD_PERIODS = 2
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_ena,
    input  wire logic                  i_brake,
    input  wire logic                  i_tick,
    input  wire logic [PWM_BITS-1:0]   i_cnt,
    input  wire logic [PWM_BITS-1:0]   i_vlim,
    input  wire logic signed [W:0]     i_mix,
    output logic                       o_pwm,
    output logic                       o_x1,
    output logic                       o_x2,
    output logic signed [PWM_BITS:0]   o_duty
);

    localparam int c_DC_W = (DEAD_PERIODS > 0) ? $clog2(DEAD_PERIODS + 1) : 1;
    localparam logic [c_DC_W-1:0]   c_DEAD_LOAD = c_DC_W'(DEAD_PERIODS);
    localparam logic [c_DC_W-1:0]   c_DEAD_ONE  = c_DC_W'(1);
    localparam logic [PWM_BITS-1:0] c_STEP      = PWM_BITS'(RAMP_STEP);

    chan_state_t          r_state;
    logic [PWM_BITS-1:0]  r_mag;
    logic                 r_dir;
    logic [c_DC_W-1:0]    r_dead;
    logic                 r_brk;

    logic signed [W:0]    w_lim;
    logic signed [W:0]    w_target;
    logic signed [W:0]    w_abs;
    logic [PWM_BITS-1:0]  w_tmag;
    logic [PWM_BITS-1:0]  w_goal;
    logic [PWM_BITS-1:0]  w_next;
    logic                 w_tsign;
    logic                 w_tzero;
    logic                 w_reversed;
    logic [1:0]           w_pins;

    assign w_lim = $signed({{(W + 1 - PWM_BITS){1'b0}}, i_vlim});

    always_comb begin
        w_target = i_mix;
        if (i_mix > w_lim) begin
            w_target = w_lim;
        end else if (i_mix < -w_lim) begin
            w_target = -w_lim;
        end
    end

    assign w_tsign    = w_target[W];
    assign w_tzero    = (w_target == '0);
    assign w_abs      = w_tsign ? -w_target : w_target;
    assign w_tmag     = PWM_BITS'(w_abs);
    // A target on the other side of zero is chased as zero until the dead interval
    assign w_reversed = !w_tzero && (w_tsign != r_dir);
    assign w_goal     = w_reversed ? '0 : w_tmag;

    always_comb begin
        w_next = w_goal;
        if (w_goal > r_mag) begin
            if ((w_goal - r_mag) > c_STEP) begin
                w_next = r_mag + c_STEP;
            end
        end else if ((r_mag - w_goal) > c_STEP) begin
            w_next = r_mag - c_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ZERO;
            r_mag   <= '0;
            r_dir   <= c_DIR_FWD;
            r_dead  <= '0;
            r_brk   <= 1'b0;
        end else begin
            r_brk <= i_brake;
            if (i_brake || !i_ena) begin
                r_state <= ST_ZERO;
                r_mag   <= '0;
                r_dead  <= '0;
            end else if (i_tick) begin
                case (r_state)
                    ST_ZERO: begin
                        r_mag <= '0;
                        if (!w_tzero) begin
                            r_dir   <= w_tsign;
                            r_state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        r_mag <= w_next;
                        if (w_next == '0) begin
                            if (w_reversed) begin
                                if (DEAD_PERIODS == 0) begin
                                    r_state <= ST_ZERO;
                                end else begin
                                    r_state <= ST_DEAD;
                                    r_dead  <= c_DEAD_LOAD;
                                end
                            end else if (w_tzero) begin
                                r_state <= ST_ZERO;
                            end
                        end
                    end
                    ST_DEAD: begin
                        r_mag <= '0;
                        if (!w_tzero && !w_reversed) begin
                            r_state <= ST_RUN;
                            r_dead  <= '0;
                        end else if (r_dead <= c_DEAD_ONE) begin
                            r_dead <= '0;
                            if (w_tzero) begin
                                r_state <= ST_ZERO;
                            end else begin
                                r_dir   <= w_tsign;
                                r_state <= ST_RUN;
                            end
                        end else begin
                            r_dead <= r_dead - 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_ZERO;
                        r_mag   <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_pins = c_PINS_COAST;
        if (r_brk) begin
            w_pins = c_PINS_BRAKE;
        end else if (r_state == ST_RUN) begin
            w_pins = (r_dir == c_DIR_REV) ? c_PINS_REV : c_PINS_FWD;
        end
    end

    assign o_pwm  = r_brk | (i_cnt < r_mag);
    assign o_x1   = w_pins[1];
    assign o_x2   = w_pins[0];
    assign o_duty = r_dir ? -$signed({1'b0, r_mag}) : $signed({1'b0, r_mag});

endmodule
`default_nettype wire

// File: rtl/motor_drive_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : motor_drive_ctrl
// Brief    : Differential mixer, shared PWM timebase and two wheel channels.
// Revision : 1.0 - initial release
// ============================================================================
module motor_drive_ctrl
    import motor_drive_ctrl_pkg::*;
#(
    parameter int W            = 16,
    parameter int PWM_BITS     = 8,
    parameter int PRESCALE     = 39,
    parameter int RAMP_STEP    = 4,
    parameter int DEAD_PERIODS = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    motor_drive_ctrl_if.slave bus
);

    localparam int c_DMAX = int'(f_dmax(PWM_BITS));
    localparam int c_PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PS_W-1:0]   c_PS_LAST  = c_PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] c_CNT_LAST = PWM_BITS'(c_DMAX - 1);
    localparam logic [PWM_BITS-1:0] c_DMAX_V   = PWM_BITS'(c_DMAX);

    logic [c_PS_W-1:0]   r_ps;
    logic [PWM_BITS-1:0] r_cnt;
    logic                r_tick;
    logic                r_stby;

    logic                w_ps_wrap;
    logic                w_wrap;
    logic [PWM_BITS-1:0] w_vlim;
    logic signed [W:0]   w_left;
    logic signed [W:0]   w_right;

    assign w_ps_wrap = (r_ps == c_PS_LAST);
    // Channels update on the same edge the counter returns to 0, so each new
    // duty covers the whole period that period_tick announces.
    assign w_wrap    = w_ps_wrap && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ps   <= '0;
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_stby <= 1'b0;
        end else begin
            r_ps <= w_ps_wrap ? '0 : r_ps + 1'b1;
            if (w_ps_wrap) begin
                r_cnt <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + 1'b1;
            end
            r_tick <= w_wrap;
            r_stby <= bus.ena | bus.brake;
        end
    end

    assign w_vlim  = (bus.vmax > c_DMAX_V) ? c_DMAX_V : bus.vmax;
    assign w_left  = {bus.vr[W-1], bus.vr} + {bus.u_k[W-1], bus.u_k};
    assign w_right = {bus.vr[W-1], bus.vr} - {bus.u_k[W-1], bus.u_k};

    assign bus.period_tick = r_tick;
    assign bus.stby        = r_stby;

    motor_channel #(
        .W            (W),
        .PWM_BITS     (PWM_BITS),
        .RAMP_STEP    (RAMP_STEP),
        .DEAD_PERIODS (DEAD_PERIODS)
    ) u_chan_a (
        .clk     (clk),
        .rst     (rst),
        .i_ena   (bus.ena),
        .i_brake (bus.brake),
        .i_tick  (w_wrap),
        .i_cnt   (r_cnt),
        .i_vlim  (w_vlim),
        .i_mix   (w_left),
        .o_pwm   (bus.pwm_a),
        .o_x1    (bus.dir_a1),
        .o_x2    (bus.dir_a2),
        .o_duty  (bus.duty_a)
    );

    motor_channel #(
        .W            (W),
        .PWM_BITS     (PWM_BITS),
        .RAMP_STEP    (RAMP_STEP),
        .DEAD_PERIODS (DEAD_PERIODS)
    ) u_chan_b (
        .clk     (clk),
        .rst     (rst),
        .i_ena   (bus.ena),
        .i_brake (bus.brake),
        .i_tick  (w_wrap),
        .i_cnt   (r_cnt),
        .i_vlim  (w_vlim),
        .i_mix   (w_right),
        .o_pwm   (bus.pwm_b),
        .o_x1    (bus.dir_b1),
        .o_x2    (bus.dir_b2),
        .o_duty  (bus.duty_b)
    );

endmodule
`default_nettype wire

// File: tb/tb_motor_drive_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_motor_drive_ctrl
// Brief    : Directed self-checking bench; PRESCALE=1 so one period = 255 clks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_motor_drive_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    motor_drive_ctrl_if #(.W(16), .PWM_BITS(8)) bus ();

    motor_drive_ctrl #(
        .W(16), .PWM_BITS(8), .PRESCALE(1), .RAMP_STEP(4), .DEAD_PERIODS(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.period_tick !== 1'b1 && n < 400);
        if (bus.period_tick !== 1'b1) begin
            checks++; errors++;
            $display("FAIL tick_timeout: no period_tick within %0d clocks", n);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    // Samples one full period starting at the tick cycle (counts 0..254)
    task automatic count_high(output int ha, output int hb);
        ha = 0; hb = 0;
        for (int i = 0; i < 255; i++) begin
            if (i != 0) @(negedge clk);
            if (bus.pwm_a === 1'b1) ha++;
            if (bus.pwm_b === 1'b1) hb++;
        end
    endtask

    task automatic test_reset();
        bus.ena = 0; bus.brake = 0; bus.u_k = 0; bus.vr = 0; bus.vmax = 0;
        rst = 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.pwm_a, bus.dir_a1, bus.dir_a2, bus.pwm_b, bus.dir_b1, bus.dir_b2,
             bus.stby, bus.period_tick} !== 8'h00) begin
            errors++;
            $display("FAIL reset_pins: got %b want 00000000", {bus.pwm_a, bus.dir_a1,
                     bus.dir_a2, bus.pwm_b, bus.dir_b1, bus.dir_b2, bus.stby, bus.period_tick});
        end
        checks++;
        if (bus.duty_a !== 9'sd0 || bus.duty_b !== 9'sd0) begin
            errors++;
            $display("FAIL reset_duty: got a=%0d b=%0d want 0/0", bus.duty_a, bus.duty_b);
        end
        rst = 0;
    endtask

    task automatic test_ramp();
        int ha, hb, exp;
        bus.ena = 1; bus.vr = 100; bus.u_k = 0; bus.vmax = 170;
        for (int i = 1; i <= 26; i++) begin
            wait_tick();
            exp = (i - 1) * 4;
            checks++;
            if (int'(bus.duty_a) !== exp || int'(bus.duty_b) !== exp) begin
                errors++;
                $display("FAIL ramp_step%0d: got a=%0d b=%0d want %0d", i, bus.duty_a, bus.duty_b, exp);
            end
        end
        checks++;
        if ({bus.dir_a1, bus.dir_a2, bus.dir_b1, bus.dir_b2, bus.stby} !== 5'b10101) begin
            errors++;
            $display("FAIL ramp_pins: got %b want 10101",
                     {bus.dir_a1, bus.dir_a2, bus.dir_b1, bus.dir_b2, bus.stby});
        end
        count_high(ha, hb);
        checks++;
        if (ha != 100 || hb != 100) begin
            errors++;
            $display("FAIL ramp_pwm_count: got a=%0d b=%0d want 100/100", ha, hb);
        end
    endtask

    task automatic test_mix();
        bus.vr = 150; bus.u_k = 60;
        wait_tick();
        checks++;
        if (int'(bus.duty_a) !== 104 || int'(bus.duty_b) !== 96) begin
            errors++;
            $display("FAIL mix_first: got a=%0d b=%0d want 104/96", bus.duty_a, bus.duty_b);
        end
        wait_ticks(19);
        checks++;
        if (int'(bus.duty_a) !== 170 || int'(bus.duty_b) !== 90) begin
            errors++;
            $display("FAIL mix_steady: got a=%0d b=%0d want 170/90", bus.duty_a, bus.duty_b);
        end
    endtask

    task automatic test_brake();
        repeat (100) @(negedge clk);
        bus.brake = 1;
        @(negedge clk);
        checks++;
        if ({bus.pwm_a, bus.dir_a1, bus.dir_a2, bus.pwm_b, bus.dir_b1, bus.dir_b2, bus.stby}
            !== 7'b1111111) begin
            errors++;
            $display("FAIL brake_pins: got %b want 1111111", {bus.pwm_a, bus.dir_a1, bus.dir_a2,
                     bus.pwm_b, bus.dir_b1, bus.dir_b2, bus.stby});
        end
        checks++;
        if (bus.duty_a !== 9'sd0 || bus.duty_b !== 9'sd0) begin
            errors++;
            $display("FAIL brake_duty: got a=%0d b=%0d want 0/0", bus.duty_a, bus.duty_b);
        end
        repeat (20) @(negedge clk);
        bus.brake = 0; bus.vr = 20; bus.u_k = 0;
        @(negedge clk);
        checks++;
        if ({bus.pwm_a, bus.dir_a1, bus.dir_a2, bus.stby} !== 4'b0001) begin
            errors++;
            $display("FAIL brake_release: got %b want 0001",
                     {bus.pwm_a, bus.dir_a1, bus.dir_a2, bus.stby});
        end
        wait_tick();
        checks++;
        if (int'(bus.duty_a) !== 0 || {bus.dir_a1, bus.dir_a2} !== 2'b10) begin
            errors++;
            $display("FAIL restart_run: got duty=%0d pins=%b want 0/10", bus.duty_a,
                     {bus.dir_a1, bus.dir_a2});
        end
        wait_tick();
        checks++;
        if (int'(bus.duty_a) !== 4) begin
            errors++;
            $display("FAIL restart_ramp: got %0d want 4", bus.duty_a);
        end
        wait_ticks(4);
        checks++;
        if (int'(bus.duty_a) !== 20 || int'(bus.duty_b) !== 20) begin
            errors++;
            $display("FAIL restart_reach: got a=%0d b=%0d want 20/20", bus.duty_a, bus.duty_b);
        end
    endtask

    task automatic test_reverse();
        int exp_d [12] = '{16, 12, 8, 4, 0, 0, 0, -4, -8, -12, -16, -20};
        logic [1:0] exp_p [12] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00,
                                   2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
        int viol = 0;
        int n;
        bus.vr = -20;
        for (int i = 0; i < 12; i++) begin
            n = 0;
            // pwm may only be high when the pins match the sign of the duty
            do begin
                @(negedge clk);
                n++;
                if (bus.pwm_a === 1'b1 &&
                    {bus.dir_a1, bus.dir_a2} !== ((bus.duty_a < 0) ? 2'b01 : 2'b10)) viol++;
            end while (bus.period_tick !== 1'b1 && n < 400);
            checks++;
            if (int'(bus.duty_a) !== exp_d[i] || {bus.dir_a1, bus.dir_a2} !== exp_p[i]) begin
                errors++;
                $display("FAIL reverse_step%0d: got duty=%0d pins=%b want %0d/%b", i,
                         bus.duty_a, {bus.dir_a1, bus.dir_a2}, exp_d[i], exp_p[i]);
            end
        end
        checks++;
        if (viol != 0 || int'(bus.duty_b) !== -20) begin
            errors++;
            $display("FAIL reverse_overlap: got viol=%0d duty_b=%0d want 0/-20", viol, bus.duty_b);
        end
    endtask

    task automatic test_disable();
        int n = 0;
        repeat (50) @(negedge clk);
        bus.ena = 0;
        @(negedge clk);
        checks++;
        if ({bus.stby, bus.pwm_a, bus.pwm_b, bus.dir_a1, bus.dir_a2} !== 5'b00000 ||
            bus.duty_a !== 9'sd0 || bus.duty_b !== 9'sd0) begin
            errors++;
            $display("FAIL disable: got stby/pwm/pins=%b duty=%0d/%0d want 00000 0/0",
                     {bus.stby, bus.pwm_a, bus.pwm_b, bus.dir_a1, bus.dir_a2},
                     bus.duty_a, bus.duty_b);
        end
        wait_tick();
        do begin
            @(negedge clk);
            n++;
        end while (bus.period_tick !== 1'b1 && n < 1000);
        checks++;
        if (n != 255) begin
            errors++;
            $display("FAIL tick_period: got %0d clocks want 255", n);
        end
        checks++;
        if (bus.stby !== 1'b0 || bus.duty_a !== 9'sd0) begin
            errors++;
            $display("FAIL disable_hold: got stby=%b duty=%0d want 0/0", bus.stby, bus.duty_a);
        end
    endtask

    task automatic test_full_scale();
        int ha, hb;
        bus.ena = 1; bus.vr = 255; bus.vmax = 255; bus.u_k = 0;
        wait_ticks(64);
        checks++;
        if (int'(bus.duty_a) !== 252) begin
            errors++;
            $display("FAIL full_near: got %0d want 252", bus.duty_a);
        end
        wait_tick();
        checks++;
        if (int'(bus.duty_a) !== 255 || int'(bus.duty_b) !== 255) begin
            errors++;
            $display("FAIL full_reach: got a=%0d b=%0d want 255/255", bus.duty_a, bus.duty_b);
        end
        count_high(ha, hb);
        checks++;
        if (ha != 255 || hb != 255) begin
            errors++;
            $display("FAIL full_pwm_high: got a=%0d b=%0d want 255/255", ha, hb);
        end
        bus.vr = 0;
        wait_ticks(63);
        checks++;
        if (int'(bus.duty_a) !== 3) begin
            errors++;
            $display("FAIL full_down: got %0d want 3", bus.duty_a);
        end
        wait_tick();
        checks++;
        if (int'(bus.duty_a) !== 0 || {bus.dir_a1, bus.dir_a2} !== 2'b00) begin
            errors++;
            $display("FAIL full_zero: got duty=%0d pins=%b want 0/00", bus.duty_a,
                     {bus.dir_a1, bus.dir_a2});
        end
        count_high(ha, hb);
        checks++;
        if (ha != 0 || hb != 0) begin
            errors++;
            $display("FAIL zero_pwm_low: got a=%0d b=%0d want 0/0", ha, hb);
        end
    endtask

    task automatic test_reset_mid_ramp();
        bus.vr = 100;
        wait_ticks(3);
        checks++;
        if (int'(bus.duty_a) !== 8) begin
            errors++;
            $display("FAIL premid_ramp: got %0d want 8", bus.duty_a);
        end
        repeat (50) @(negedge clk);
        rst = 1;
        #1;
        checks++;
        if ({bus.pwm_a, bus.dir_a1, bus.dir_a2, bus.pwm_b, bus.dir_b1, bus.dir_b2,
             bus.stby, bus.period_tick} !== 8'h00 ||
            bus.duty_a !== 9'sd0 || bus.duty_b !== 9'sd0) begin
            errors++;
            $display("FAIL mid_reset: got pins=%b duty=%0d/%0d want 00000000 0/0",
                     {bus.pwm_a, bus.dir_a1, bus.dir_a2, bus.pwm_b, bus.dir_b1, bus.dir_b2,
                      bus.stby, bus.period_tick}, bus.duty_a, bus.duty_b);
        end
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_mix();
        test_brake();
        test_reverse();
        test_disable();
        test_full_scale();
        test_reset_mid_ramp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
